// File: rtl/impact_access_sequencer_if.sv
// Command/response bundle between a requester and the impact access sequencer.
// The requester drives the master side; the sequencer owns the slave side.
interface impact_access_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic       cmd_byte_mode;
    logic       cmd_trunc;
    logic [1:0] cmd_byte_sel;
    logic [1:0] cmd_proj_sel;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_is_read;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_write, cmd_byte_mode, cmd_trunc,
               cmd_byte_sel, cmd_proj_sel, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_is_read, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_byte_mode, cmd_trunc,
               cmd_byte_sel, cmd_proj_sel, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_is_read, rsp_data, busy
    );
endinterface

// File: rtl/impact_access_sequencer.sv
// Sequences one memory-macro access per command: setup, precharge, word-line
// settle, sense/drive, done. Macro strobes are registered from the next state.
module impact_access_sequencer #(
    parameter int PRE_CYCLES = 2,
    parameter int WL_CYCLES  = 1,
    parameter int ACT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    impact_access_sequencer_if.slave    bus,
    output logic                        PreCharge,
    output logic                        WL_enable,
    output logic                        ReadEnable,
    output logic                        WriteEnable,
    output logic                        Data_In_Enable,
    output logic                        Trunc_Enable,
    output logic                        Byte_Mode_Enable,
    output logic [1:0]                  Byte_Select,
    output logic [1:0]                  Proj_Select,
    output logic [7:0]                  Data_In,
    input  logic [7:0]                  Data_Out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_WL    = 3'd3;
    localparam logic [2:0] S_ACT   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] WL_LOAD  = 4'(WL_CYCLES - 1);
    localparam logic [3:0] ACT_LOAD = 4'(ACT_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       active_d;

    logic       write_q, write_d;
    logic       byteMode_q, byteMode_d;
    logic       trunc_q, trunc_d;
    logic [1:0] byteSel_q, byteSel_d;
    logic [1:0] projSel_q, projSel_d;
    logic [7:0] wdata_q, wdata_d;

    logic       preCharge_q, wlEnable_q, readEnable_q, writeEnable_q;
    logic       truncOut_q, byteModeOut_q;
    logic [1:0] byteSelOut_q, projSelOut_q;
    logic [7:0] dataInOut_q;
    logic       rspValid_q, rspIsRead_q;
    logic [7:0] rspData_q;

    // Each multi-cycle state runs its counter down to zero before moving on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_PRE;
                cnt_d   = PRE_LOAD;
            end
            S_PRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WL;
                    cnt_d   = WL_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WL: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACT;
                    cnt_d   = ACT_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        write_d    = accept ? bus.cmd_write     : write_q;
        byteMode_d = accept ? bus.cmd_byte_mode : byteMode_q;
        trunc_d    = accept ? bus.cmd_trunc     : trunc_q;
        byteSel_d  = accept ? bus.cmd_byte_sel  : byteSel_q;
        projSel_d  = accept ? bus.cmd_proj_sel  : projSel_q;
        wdata_d    = accept ? bus.cmd_wdata     : wdata_q;
        active_d   = (state_d != S_IDLE);
    end

    // Outputs are decoded from the next state so they change exactly at state edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            write_q       <= 1'b0;
            byteMode_q    <= 1'b0;
            trunc_q       <= 1'b0;
            byteSel_q     <= 2'd0;
            projSel_q     <= 2'd0;
            wdata_q       <= 8'd0;
            preCharge_q   <= 1'b0;
            wlEnable_q    <= 1'b0;
            readEnable_q  <= 1'b0;
            writeEnable_q <= 1'b0;
            truncOut_q    <= 1'b0;
            byteModeOut_q <= 1'b0;
            byteSelOut_q  <= 2'd0;
            projSelOut_q  <= 2'd0;
            dataInOut_q   <= 8'd0;
            rspValid_q    <= 1'b0;
            rspIsRead_q   <= 1'b0;
            rspData_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            byteMode_q    <= byteMode_d;
            trunc_q       <= trunc_d;
            byteSel_q     <= byteSel_d;
            projSel_q     <= projSel_d;
            wdata_q       <= wdata_d;
            preCharge_q   <= (state_d == S_PRE);
            wlEnable_q    <= (state_d == S_WL) || (state_d == S_ACT);
            readEnable_q  <= (state_d == S_ACT) && !write_d;
            writeEnable_q <= (state_d == S_ACT) && write_d;
            truncOut_q    <= active_d && trunc_d;
            byteModeOut_q <= active_d && byteMode_d;
            byteSelOut_q  <= active_d ? byteSel_d : 2'd0;
            projSelOut_q  <= active_d ? projSel_d : 2'd0;
            dataInOut_q   <= active_d ? wdata_d : 8'd0;
            rspValid_q    <= (state_d == S_DONE);
            rspIsRead_q   <= (state_d == S_DONE) && !write_q;
            if ((state_q == S_ACT) && (cnt_q == 4'd0) && !write_q) begin
                rspData_q <= Data_Out;
            end
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.rsp_valid   = rspValid_q;
    assign bus.rsp_is_read = rspIsRead_q;
    assign bus.rsp_data    = rspData_q;

    assign PreCharge        = preCharge_q;
    assign WL_enable        = wlEnable_q;
    assign ReadEnable       = readEnable_q;
    assign WriteEnable      = writeEnable_q;
    assign Data_In_Enable   = writeEnable_q;
    assign Trunc_Enable     = truncOut_q;
    assign Byte_Mode_Enable = byteModeOut_q;
    assign Byte_Select      = byteSelOut_q;
    assign Proj_Select      = projSelOut_q;
    assign Data_In          = dataInOut_q;

endmodule

// File: tb/tb_impact_access_sequencer.sv
// Scoreboard bench: a default-timing and a swept-timing sequencer are driven with
// random commands and compared cycle by cycle against a phase-offset reference model.
module tb_impact_access_sequencer;

    typedef struct {
        logic       write;
        logic       byteMode;
        logic       trunc;
        logic [1:0] byteSel;
        logic [1:0] projSel;
        logic [7:0] wdata;
        logic       forceData;
        int         gap;
    } cmd_t;

    typedef struct {
        logic       isRead;
        logic [7:0] data;
        int         acceptCycle;
    } rsp_t;

    logic clk = 1'b0;
    int   nChecks = 0;
    int   nFails = 0;
    int   doneCount = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(output cmd_t c);
        c.write     = 1'($urandom_range(0, 1));
        c.byteMode  = 1'($urandom_range(0, 1));
        c.trunc     = 1'($urandom_range(0, 1));
        c.byteSel   = 2'($urandom_range(0, 3));
        c.projSel   = 2'($urandom_range(0, 3));
        c.wdata     = 8'($urandom);
        c.forceData = 1'b0;
        c.gap       = int'($urandom_range(0, 3));
    endtask

    task automatic markDone();
        doneCount++;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen
        localparam int    P   = (g == 0) ? 2 : 1;
        localparam int    W   = (g == 0) ? 1 : 3;
        localparam int    A   = (g == 0) ? 2 : 1;
        localparam int    L   = 1 + P + W + A;
        localparam string TAG = (g == 0) ? "dflt" : "sweep";

        impact_access_sequencer_if bus ();
        logic       rstL;
        logic       pc, wl, re, we, die, te, bme;
        logic [1:0] bs, ps;
        logic [7:0] di;
        logic [7:0] dataOut;
        logic       forceData;

        impact_access_sequencer #(
            .PRE_CYCLES(P),
            .WL_CYCLES (W),
            .ACT_CYCLES(A)
        ) dut (
            .clk             (clk),
            .rst             (rstL),
            .bus             (bus),
            .PreCharge       (pc),
            .WL_enable       (wl),
            .ReadEnable      (re),
            .WriteEnable     (we),
            .Data_In_Enable  (die),
            .Trunc_Enable    (te),
            .Byte_Mode_Enable(bme),
            .Byte_Select     (bs),
            .Proj_Select     (ps),
            .Data_In         (di),
            .Data_Out        (dataOut)
        );

        int         k = -1;
        int         cyc = 0;
        int         acceptCount = 0;
        int         acceptCycleM = 0;
        cmd_t       m;
        logic [7:0] rspDataModel = 8'h00;
        rsp_t       expQ[$];

        // Macro read data changes every cycle unless a directed value is pinned.
        initial begin : macroData
            dataOut = 8'h00;
            forever begin
                @(negedge clk);
                dataOut = forceData ? 8'h3C : 8'($urandom);
            end
        end

        // Reference: k counts edges since acceptance; the phase follows from the durations.
        initial begin : model
            rsp_t e;
            forever begin
                @(posedge clk);
                cyc++;
                if (rstL) begin
                    k = -1;
                    rspDataModel = 8'h00;
                end else if (k < 0) begin
                    if (bus.cmd_valid) begin
                        k = 0;
                        m.write    = bus.cmd_write;
                        m.byteMode = bus.cmd_byte_mode;
                        m.trunc    = bus.cmd_trunc;
                        m.byteSel  = bus.cmd_byte_sel;
                        m.projSel  = bus.cmd_proj_sel;
                        m.wdata    = bus.cmd_wdata;
                        acceptCycleM = cyc;
                        acceptCount++;
                    end
                end else begin
                    if (k == P + W + A) begin
                        if (!m.write) rspDataModel = dataOut;
                        e.isRead      = !m.write;
                        e.data        = rspDataModel;
                        e.acceptCycle = acceptCycleM;
                        expQ.push_back(e);
                    end
                    k++;
                    if (k > L) k = -1;
                end
            end
        end

        initial begin : monitor
            logic        idle, pre, wlP, act, done;
            logic [31:0] expVec, actVec;
            rsp_t        e;
            forever begin
                @(negedge clk);
                idle = (k < 0);
                pre  = (k >= 1) && (k <= P);
                wlP  = (k > P) && (k <= P + W);
                act  = (k > P + W) && (k <= P + W + A);
                done = (k == L);
                expVec = {2'b00, idle, !idle, pre, wlP || act, act && !m.write,
                          act && m.write, act && m.write, !idle && m.trunc,
                          !idle && m.byteMode, idle ? 2'b00 : m.byteSel,
                          idle ? 2'b00 : m.projSel, idle ? 8'h00 : m.wdata,
                          done, rspDataModel};
                actVec = {2'b00, bus.cmd_ready, bus.busy, pc, wl, re, we, die, te,
                          bme, bs, ps, di, bus.rsp_valid, bus.rsp_data};
                checkOutput({TAG, "_outputs"}, actVec, expVec);
                checkOutput({TAG, "_inv_pc_wl"}, 32'(pc && wl), 32'd0);
                checkOutput({TAG, "_inv_re_we"}, 32'(re && we), 32'd0);
                if (bus.rsp_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput({TAG, "_rsp_spurious"}, 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({TAG, "_rsp_is_read"}, 32'(bus.rsp_is_read), 32'(e.isRead));
                        checkOutput({TAG, "_rsp_data"}, 32'(bus.rsp_data), 32'(e.data));
                        checkOutput({TAG, "_rsp_latency"}, 32'(cyc - e.acceptCycle), 32'(L));
                    end
                end
            end
        end

        initial begin : driver
            cmd_t c;
            cmd_t list[$];
            int   a0;
            rstL              = 1'b1;
            forceData         = 1'b0;
            bus.cmd_valid     = 1'b0;
            bus.cmd_write     = 1'b0;
            bus.cmd_byte_mode = 1'b0;
            bus.cmd_trunc     = 1'b0;
            bus.cmd_byte_sel  = 2'd0;
            bus.cmd_proj_sel  = 2'd0;
            bus.cmd_wdata     = 8'h00;

            // Directed write then back-to-back read with pinned macro data.
            c.write = 1'b1; c.byteMode = 1'b0; c.trunc = 1'b0; c.byteSel = 2'd2;
            c.projSel = 2'd1; c.wdata = 8'hA5; c.forceData = 1'b0; c.gap = 0;
            list.push_back(c);
            c.write = 1'b0; c.byteMode = 1'b1; c.trunc = 1'b1; c.byteSel = 2'd1;
            c.projSel = 2'd3; c.wdata = 8'h00; c.forceData = 1'b1; c.gap = 8;
            list.push_back(c);
            for (int i = 0; i < 30; i++) begin
                applyStimulus(c);
                list.push_back(c);
            end

            repeat (2) @(negedge clk);
            bus.cmd_valid = 1'b1;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            rstL = 1'b0;
            @(negedge clk);

            foreach (list[i]) begin
                bus.cmd_write     = list[i].write;
                bus.cmd_byte_mode = list[i].byteMode;
                bus.cmd_trunc     = list[i].trunc;
                bus.cmd_byte_sel  = list[i].byteSel;
                bus.cmd_proj_sel  = list[i].projSel;
                bus.cmd_wdata     = list[i].wdata;
                forceData         = list[i].forceData;
                bus.cmd_valid     = 1'b1;
                a0 = acceptCount;
                for (int t = 0; t < 64 && acceptCount == a0; t++) @(negedge clk);
                if (acceptCount == a0) checkOutput({TAG, "_accept_timeout"}, 32'd0, 32'd1);
                if (list[i].gap > 0) begin
                    bus.cmd_valid = 1'b0;
                    repeat (list[i].gap) @(negedge clk);
                end
            end
            bus.cmd_valid = 1'b0;
            forceData = 1'b0;
            for (int t = 0; t < 64 && k >= 0; t++) @(negedge clk);

            // Read aborted by reset in its first ACT cycle.
            bus.cmd_write = 1'b0;
            bus.cmd_wdata = 8'h77;
            bus.cmd_valid = 1'b1;
            a0 = acceptCount;
            for (int t = 0; t < 64 && acceptCount == a0; t++) @(negedge clk);
            if (acceptCount == a0) checkOutput({TAG, "_abort_accept_timeout"}, 32'd0, 32'd1);
            bus.cmd_valid = 1'b0;
            for (int t = 0; t < 64 && k != P + W + 1; t++) @(negedge clk);
            rstL = 1'b1;
            @(negedge clk);
            rstL = 1'b0;
            repeat (L + 4) @(negedge clk);

            checkOutput({TAG, "_rsp_leftover"}, 32'(expQ.size()), 32'd0);
            markDone();
        end
    end

    initial begin : supervisor
        for (int t = 0; t < 20000 && doneCount < 2; t++) @(posedge clk);
        if (doneCount < 2) checkOutput("run_timeout", 32'(doneCount), 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
